// File: rtl/dm_pkg.sv
// Shared definitions for the data memory: FSM states, default widths
// and the index-width helper used to size the clear sweep.
package dm_pkg;

    localparam int DM_ADDR_W = 12;
    localparam int DM_DATA_W = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dm_state_e;

    // Bits needed to index `depth` words; never less than one.
    function automatic int dm_log2(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Single-port synchronous RAM; rdata is registered and only reloads on a
// read strobe, so it holds the last read value between reads.
module dm_array
    import dm_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int IDX_W      = 12,
    parameter int DATA_WIDTH = DM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents are not reset here; the owner sweeps zeros in after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory for the core's DM_* port, with a zeroing sweep
// after reset, a sticky protocol-error flag and saturating access counters.
module data_memory
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_W,
    parameter int DATA_WIDTH = DM_DATA_W,
    parameter int DEPTH      = 4096,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DM_enable,
    input  logic                  DM_read,
    input  logic                  DM_write,
    input  logic [ADDR_WIDTH-1:0] DM_address,
    input  logic [DATA_WIDTH-1:0] DM_in,
    output logic [DATA_WIDTH-1:0] DM_out,
    output logic                  DM_busy,
    output logic                  DM_error,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    localparam int IDX_W = dm_log2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    dm_state_e             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;

    logic                  rd_acc;
    logic                  wr_acc;
    logic                  req;
    logic                  conflict;
    logic                  arr_we;
    logic                  arr_re;
    logic [IDX_W-1:0]      arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata;

    // Upper address bits are dropped so accesses alias modulo DEPTH.
    always_comb begin
        req       = DM_enable & (DM_read | DM_write);
        conflict  = DM_enable & DM_read & DM_write;
        rd_acc    = ~rst & (state_q == READY) & DM_enable & DM_read & ~DM_write;
        wr_acc    = ~rst & (state_q == READY) & DM_enable & DM_write & ~DM_read;

        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = DM_address[IDX_W-1:0];
        arr_wdata = DM_in;

        case (state_q)
            CLEAR: begin
                arr_we    = ~rst;
                arr_addr  = idx_q;
                arr_wdata = '0;
                idx_d     = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                arr_we = wr_acc;
                arr_re = rd_acc;
            end
            default: begin
                state_d = CLEAR;
                busy_d  = 1'b1;
            end
        endcase

        err_d = err_q | conflict | (req & (state_q == CLEAR));

        rd_cnt_d = rd_cnt_q;
        if (rd_acc && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        wr_cnt_d = wr_cnt_q;
        if (wr_acc && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    dm_array #(
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (DM_out)
    );

    assign DM_busy  = busy_q;
    assign DM_error = err_q;
    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with a 16-word array: clear sweep timing,
// read/write, protocol errors, aliasing, mid-sweep reset and counter saturation.
module tb_data_memory;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 16;
    localparam int CNT_WIDTH  = 16;

    logic                  clk;
    logic                  rst;
    logic                  DM_enable;
    logic                  DM_read;
    logic                  DM_write;
    logic [ADDR_WIDTH-1:0] DM_address;
    logic [DATA_WIDTH-1:0] DM_in;
    logic [DATA_WIDTH-1:0] DM_out;
    logic                  DM_busy;
    logic                  DM_error;
    logic [CNT_WIDTH-1:0]  rd_count;
    logic [CNT_WIDTH-1:0]  wr_count;

    int nCompared;
    int nMismatched;

    data_memory #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .DM_enable  (DM_enable),
        .DM_read    (DM_read),
        .DM_write   (DM_write),
        .DM_address (DM_address),
        .DM_in      (DM_in),
        .DM_out     (DM_out),
        .DM_busy    (DM_busy),
        .DM_error   (DM_error),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the rising edge take them, sample on the falling edge.
    task automatic applyStimulus(input logic en, input logic rd, input logic wr,
                                 input logic [ADDR_WIDTH-1:0] addr,
                                 input logic [DATA_WIDTH-1:0] din);
        DM_enable  = en;
        DM_read    = rd;
        DM_write   = wr;
        DM_address = addr;
        DM_in      = din;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " DM_out"},   DM_out,   32'h0);
        checkOutput({tag, " DM_busy"},  {31'b0, DM_busy},  32'h1);
        checkOutput({tag, " DM_error"}, {31'b0, DM_error}, 32'h0);
        checkOutput({tag, " rd_count"}, {16'b0, rd_count}, 32'h0);
        checkOutput({tag, " wr_count"}, {16'b0, wr_count}, 32'h0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst         = 1'b1;
        DM_enable   = 1'b0;
        DM_read     = 1'b0;
        DM_write    = 1'b0;
        DM_address  = '0;
        DM_in       = '0;
        @(negedge clk);

        // Reset values, then sweep: busy high through edge 15, low after edge 16.
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        checkResetState("reset");
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
            checkOutput($sformatf("sweep busy edge %0d", i), {31'b0, DM_busy},
                        (i < DEPTH) ? 32'h1 : 32'h0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 12'(a), 32'h0);
            checkOutput($sformatf("zero word %0d", a), DM_out, 32'h0);
        end
        checkOutput("rd_count after zero scan", {16'b0, rd_count}, 32'd16);

        // Disabled strobes and an empty enabled access change nothing.
        applyStimulus(1'b0, 1'b1, 1'b1, 12'h5, 32'hFF);
        checkOutput("disabled error", {31'b0, DM_error}, 32'h0);
        checkOutput("disabled wr_count", {16'b0, wr_count}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h5, 32'hFF);
        checkOutput("noop error", {31'b0, DM_error}, 32'h0);
        checkOutput("noop rd_count", {16'b0, rd_count}, 32'd16);

        // Write then read the same word on the next cycle.
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h5, 32'hDEADBEEF);
        checkOutput("write keeps DM_out", DM_out, 32'h0);
        checkOutput("wr_count after write", {16'b0, wr_count}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h5, 32'h0);
        checkOutput("read back 5", DM_out, 32'hDEADBEEF);
        checkOutput("rd_count after read 5", {16'b0, rd_count}, 32'd17);

        // Read+write conflict: flagged, nothing performed.
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h3, 32'h11);
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h3, 32'h22);
        checkOutput("conflict error", {31'b0, DM_error}, 32'h1);
        checkOutput("conflict DM_out", DM_out, 32'hDEADBEEF);
        checkOutput("conflict rd_count", {16'b0, rd_count}, 32'd17);
        checkOutput("conflict wr_count", {16'b0, wr_count}, 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h3, 32'h0);
        checkOutput("word 3 kept", DM_out, 32'h11);
        checkOutput("error sticky", {31'b0, DM_error}, 32'h1);

        // Upper address bits alias onto the 16-word array.
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h013, 32'hA);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h003, 32'h0);
        checkOutput("alias read 3", DM_out, 32'hA);
        checkOutput("wr_count alias", {16'b0, wr_count}, 32'd3);

        // Reset at sweep index 7, with a write pending in the same cycle.
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        end
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h5, 32'h77);
        checkResetState("mid-sweep reset");
        rst = 1'b0;

        // Accesses during the restarted sweep are dropped and flagged.
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 3) begin
                applyStimulus(1'b1, 1'b1, 1'b0, 12'h0, 32'h0);
                checkOutput("clear read error", {31'b0, DM_error}, 32'h1);
                checkOutput("clear read rd_count", {16'b0, rd_count}, 32'h0);
            end else if (i == 10) begin
                applyStimulus(1'b1, 1'b0, 1'b1, 12'h2, 32'h5);
                checkOutput("clear write wr_count", {16'b0, wr_count}, 32'h0);
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
            end
            checkOutput($sformatf("resweep busy edge %0d", i), {31'b0, DM_busy},
                        (i < DEPTH) ? 32'h1 : 32'h0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 12'(a), 32'h0);
            checkOutput($sformatf("cleared word %0d", a), DM_out, 32'h0);
        end
        checkOutput("resweep rd_count", {16'b0, rd_count}, 32'd16);
        checkOutput("resweep error held", {31'b0, DM_error}, 32'h1);

        // Read counter saturates at 0xFFFF.
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        end
        checkOutput("sat start busy", {31'b0, DM_busy}, 32'h0);
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 12'(i % DEPTH), 32'h0);
        end
        checkOutput("rd_count saturated", {16'b0, rd_count}, 32'h0000FFFF);
        checkOutput("sat wr_count", {16'b0, wr_count}, 32'h0);
        checkOutput("sat error", {31'b0, DM_error}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Word-addressed data memory that answers the CPU core's DM_* initiator port: it accepts the enable/read/write strobes, address and write data driven by the core, and returns read data on DM_out. After every reset it runs a self-clearing sweep so simulations and FPGA builds start from known-zero contents. It also keeps sticky protocol-error detection and saturating access counters for bring-up and debug.

## Interface
- ADDR_WIDTH, 12: width of DM_address; word address, no byte lanes.
- DATA_WIDTH, 32: word width.
- DEPTH, 4096: number of words, at most 2**ADDR_WIDTH. Address bits above log2(DEPTH) are ignored, so accesses alias modulo DEPTH.
- CNT_WIDTH, 16: width of each access counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- DM_enable  in  1  access strobe from the core; qualifies DM_read and DM_write.
- DM_read  in  1  read request.
- DM_write  in  1  write request.
- DM_address  in  ADDR_WIDTH  word address.
- DM_in  in  DATA_WIDTH  write data, produced by the core's regfile.
- DM_out  out  DATA_WIDTH  registered read data.
- DM_busy  out  1  high while the clear sweep runs; all accesses are dropped while high.
- DM_error  out  1  sticky protocol-error flag.
- rd_count  out  CNT_WIDTH  accepted reads, saturating.
- wr_count  out  CNT_WIDTH  accepted writes, saturating.

## Operation
- FSM states: CLEAR, READY.
- Clock edge with rst=1:
  - state becomes CLEAR and the sweep index becomes 0;
  - DM_out, DM_error, rd_count and wr_count become 0;
  - DM_busy becomes 1.
- CLEAR:
  - each cycle writes 0 to the word at the sweep index, then increments the index;
  - on the edge that writes word DEPTH-1, the next state is READY.
- READY accepts the following accesses:
  - read: DM_enable=1, DM_read=1, DM_write=0. DM_out is loaded with mem[addr] and rd_count increments.
  - write: DM_enable=1, DM_write=1, DM_read=0. mem[addr] is loaded with DM_in and wr_count increments. DM_out is unchanged.
- With DM_enable=0, DM_read and DM_write are don't-care. Nothing changes and no error is raised.
- Error conditions set DM_error to 1, which holds until rst:
  - DM_enable=1 with DM_read=1 and DM_write=1: neither operation is performed and DM_out holds;
  - DM_enable=1 with DM_read or DM_write high while in CLEAR: the access is dropped.
- DM_enable=1 with DM_read=0 and DM_write=0 is a no-op and raises no error.
- DM_out holds its value until the next accepted read; it is never driven from a write.
- Counters stick at all-ones (2**CNT_WIDTH - 1) and never wrap.

## Timing
- Reset values of all outputs: DM_out=0, DM_busy=1, DM_error=0, rd_count=0, wr_count=0.
- DM_busy drops exactly DEPTH cycles after the first clock edge with rst=0. With DEPTH=4096, the first accepted access is on edge 4097.
- Read latency is 1 cycle. An access sampled at edge N has its data on DM_out after edge N, valid throughout cycle N+1 and beyond.
- Write commits at edge N. A read of the same address sampled at edge N+1 returns the new data; no bypass path is needed.
- Back-to-back accesses are accepted every cycle with no throughput limit. This covers the core's multi-cycle memaccess/writeback sequencing.
- rst asserted mid-sweep or mid-operation restarts CLEAR from index 0. Contents written before the reset are cleared.
- rst has priority over every access in the same cycle.

## Structure
- Package dm_pkg holds:
  - the state enum (CLEAR, READY);
  - the DM_ADDR_W=12 and DM_DATA_W=32 defaults shared with the core top-level;
  - a function computing log2(DEPTH) for the sweep index width.
- One sub-module, dm_array: a single-port synchronous RAM with we, addr, wdata and a registered rdata. During CLEAR the port is muxed to the sweep index with wdata=0.
- The FSM, error logic and counters live in data_memory.

## Test plan
- Reset then idle, DEPTH=16 -> DM_busy=1 for 16 cycles and 0 from cycle 17; reading every word returns 0.
- Write 0xDEADBEEF to address 5, then read address 5 on the very next cycle -> DM_out=0xDEADBEEF one cycle later, wr_count=1, rd_count=1.
- DM_enable=1 with DM_read=DM_write=1 at address 3 holding 0x11 -> DM_error=1 next cycle, mem[3] stays 0x11, DM_out unchanged, counters unchanged.
- Read during CLEAR -> DM_error=1 and rd_count=0. Write address 2 = 0x5 issued during CLEAR -> after the sweep, mem[2]=0.
- DEPTH=16, write 0xA to address 0x013 -> read of address 3 returns 0xA (aliasing). Then apply 70000 reads with CNT_WIDTH=16 -> rd_count=0xFFFF.
- Assert rst mid-sweep at index 7 after mem holds data -> sweep restarts at 0, outputs return to reset values, all words read 0 afterwards.
